// File: rtl/seven_seg_pkg.sv
// Shared constants for the 4-digit 7-segment scan driver.
// Glyphs are {g,f,e,d,c,b,a}, active-low (common-anode display).
// Contents:
//   SEG_BLANK, SEG_DASH, SEG_DIGIT[0:9] glyph constants
//   DIG_SEC1..DIG_MIN10 digit index constants (0..3)
//   blink_phase_e       visible/hidden blink phase
package seven_seg_pkg;

    localparam logic [6:0] SEG_BLANK = 7'b1111111;
    localparam logic [6:0] SEG_DASH  = 7'b0111111;

    localparam logic [6:0] SEG_DIGIT [0:9] = '{
        7'b1000000,  // 0
        7'b1111001,  // 1
        7'b0100100,  // 2
        7'b0110000,  // 3
        7'b0011001,  // 4
        7'b0010010,  // 5
        7'b0000010,  // 6
        7'b1111000,  // 7
        7'b0000000,  // 8
        7'b0010000   // 9
    };

    localparam logic [1:0] DIG_SEC1  = 2'd0;
    localparam logic [1:0] DIG_SEC10 = 2'd1;
    localparam logic [1:0] DIG_MIN1  = 2'd2;
    localparam logic [1:0] DIG_MIN10 = 2'd3;

    typedef enum logic {
        PhVisible = 1'b0,
        PhHidden  = 1'b1
    } blink_phase_e;

endpackage

// File: rtl/bcd_to_seg.sv
// Combinational BCD to 7-segment glyph decoder.
// Ports:
//   bcd  in  4  BCD code; 10-15 are shown as a dash, not corrected
//   seg  out 7  {g,f,e,d,c,b,a}, active-low
module bcd_to_seg
    import seven_seg_pkg::*;
(
    input  logic [3:0] bcd,
    output logic [6:0] seg
);

    always_comb begin
        seg = SEG_DASH;
        case (bcd)
            4'd0: seg = SEG_DIGIT[0];
            4'd1: seg = SEG_DIGIT[1];
            4'd2: seg = SEG_DIGIT[2];
            4'd3: seg = SEG_DIGIT[3];
            4'd4: seg = SEG_DIGIT[4];
            4'd5: seg = SEG_DIGIT[5];
            4'd6: seg = SEG_DIGIT[6];
            4'd7: seg = SEG_DIGIT[7];
            4'd8: seg = SEG_DIGIT[8];
            4'd9: seg = SEG_DIGIT[9];
            default: seg = SEG_DASH;
        endcase
    end

endmodule

// File: rtl/seven_seg_scan.sv
// Time-multiplexed 4-digit common-anode 7-segment driver for the stopwatch digits.
// A snapshot of all four digits is taken once per full scan so a scan never mixes
// two counter states. Each digit slot is one blank (anti-ghosting) cycle plus
// REFRESH_DIV-1 lit cycles. In adjust mode the selected digit pair blinks.
// Optional build macro: LEADING_ZERO_BLANK_EN blanks the minutes-tens digit when it is 0.
// Ports:
//   clk, rst                   clock, synchronous active-high reset
//   sec_1s_in .. min_10s_in    BCD digits from the counter
//   adj                        adjust mode, enables blinking
//   sel                        1 = blink seconds pair, 0 = blink minutes pair
//   an                         digit enables, active-low, an[0] = seconds units
//   seg                        segments {g,f,e,d,c,b,a}, active-low
//   dp                         decimal point, active-low, lit only on digit 2
module seven_seg_scan
    import seven_seg_pkg::*;
#(
    parameter int unsigned REFRESH_DIV = 100000,
    parameter int unsigned BLINK_DIV   = 25000000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] sec_1s_in,
    input  logic [3:0] sec_10s_in,
    input  logic [3:0] min_1s_in,
    input  logic [3:0] min_10s_in,
    input  logic       adj,
    input  logic       sel,
    output logic [3:0] an,
    output logic [6:0] seg,
    output logic       dp
);

    localparam int unsigned RCNT_W = $clog2(REFRESH_DIV);
    localparam int unsigned BCNT_W = $clog2(BLINK_DIV);

    logic [RCNT_W-1:0] rcnt_q;
    logic [1:0]        idx_q;
    logic [3:0]        snap_q [4];
    logic [BCNT_W-1:0] bcnt_q;
    blink_phase_e      phase_q;
    logic [3:0]        an_q;
    logic [6:0]        seg_q;
    logic              dp_q;

    logic       rcnt_last;
    logic       bcnt_last;
    logic       pair_sel;
    logic [6:0] dec_seg;
    logic [6:0] lit_seg;

    assign rcnt_last = (rcnt_q == RCNT_W'(REFRESH_DIV - 1));
    assign bcnt_last = (bcnt_q == BCNT_W'(BLINK_DIV - 1));

    bcd_to_seg u_dec (
        .bcd (snap_q[idx_q]),
        .seg (dec_seg)
    );

    // Digit currently in the pair chosen for blinking.
    assign pair_sel = sel ? (idx_q == DIG_SEC1 || idx_q == DIG_SEC10)
                          : (idx_q == DIG_MIN1 || idx_q == DIG_MIN10);

    always_comb begin
        lit_seg = dec_seg;
        // adj is used directly so dropping it unhides on the very next lit cycle.
        if (adj && (phase_q == PhHidden) && pair_sel) begin
            lit_seg = SEG_BLANK;
        end
`ifdef LEADING_ZERO_BLANK_EN
        if ((idx_q == DIG_MIN10) && (snap_q[DIG_MIN10] == 4'd0)) begin
            lit_seg = SEG_BLANK;
        end
`endif
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rcnt_q            <= '0;
            idx_q             <= DIG_SEC1;
            snap_q[DIG_SEC1]  <= 4'd0;
            snap_q[DIG_SEC10] <= 4'd0;
            snap_q[DIG_MIN1]  <= 4'd0;
            snap_q[DIG_MIN10] <= 4'd0;
            bcnt_q            <= '0;
            phase_q           <= PhVisible;
            an_q              <= 4'b1111;
            seg_q             <= SEG_BLANK;
            dp_q              <= 1'b1;
        end else begin
            if (rcnt_last) begin
                // Blank cycle between slots; also the point where a new scan starts.
                rcnt_q <= '0;
                idx_q  <= idx_q + 2'd1;
                an_q   <= 4'b1111;
                seg_q  <= SEG_BLANK;
                dp_q   <= 1'b1;
                if (idx_q == DIG_MIN10) begin
                    snap_q[DIG_SEC1]  <= sec_1s_in;
                    snap_q[DIG_SEC10] <= sec_10s_in;
                    snap_q[DIG_MIN1]  <= min_1s_in;
                    snap_q[DIG_MIN10] <= min_10s_in;
                end
            end else begin
                rcnt_q <= rcnt_q + RCNT_W'(1);
                an_q   <= ~(4'b0001 << idx_q);
                seg_q  <= lit_seg;
                dp_q   <= (idx_q != DIG_MIN1);
            end

            if (!adj) begin
                bcnt_q  <= '0;
                phase_q <= PhVisible;
            end else if (bcnt_last) begin
                bcnt_q  <= '0;
                phase_q <= (phase_q == PhVisible) ? PhHidden : PhVisible;
            end else begin
                bcnt_q <= bcnt_q + BCNT_W'(1);
            end
        end
    end

    assign an  = an_q;
    assign seg = seg_q;
    assign dp  = dp_q;

endmodule

// File: tb/tb_seven_seg_scan.sv
// Scoreboard bench for seven_seg_scan with REFRESH_DIV=4, BLINK_DIV=16.
// The stimulus thread pushes the hand-computed pin state expected after each clock
// edge; a monitor pops and compares on the following falling edge.
module tb_seven_seg_scan;

    localparam logic [6:0] BL   = 7'b1111111;
    localparam logic [6:0] DASH = 7'b0111111;
    localparam logic [6:0] G0   = 7'b1000000;
    localparam logic [6:0] G1   = 7'b1111001;
    localparam logic [6:0] G2   = 7'b0100100;
    localparam logic [6:0] G3   = 7'b0110000;
    localparam logic [6:0] G4   = 7'b0011001;
    localparam logic [6:0] G5   = 7'b0010010;
    localparam logic [6:0] G7   = 7'b1111000;
`ifdef LEADING_ZERO_BLANK_EN
    localparam logic [6:0] Z3   = BL;
`else
    localparam logic [6:0] Z3   = G0;
`endif

    logic       clk = 1'b0;
    logic       rst;
    logic [3:0] sec_1s_in, sec_10s_in, min_1s_in, min_10s_in;
    logic       adj, sel;
    logic [3:0] an;
    logic [6:0] seg;
    logic       dp;

    seven_seg_scan #(
        .REFRESH_DIV (4),
        .BLINK_DIV   (16)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .sec_1s_in  (sec_1s_in),
        .sec_10s_in (sec_10s_in),
        .min_1s_in  (min_1s_in),
        .min_10s_in (min_10s_in),
        .adj        (adj),
        .sel        (sel),
        .an         (an),
        .seg        (seg),
        .dp         (dp)
    );

    always #5 clk = ~clk;

    logic [11:0] exp_q [$];
    string       tag_q [$];
    int          n_checks = 0;
    int          n_pass   = 0;
    logic [11:0] mon_exp;
    string       mon_tag;

    always @(negedge clk) begin
        if (exp_q.size() > 0) begin
            mon_exp = exp_q.pop_front();
            mon_tag = tag_q.pop_front();
            n_checks++;
            if ({an, seg, dp} === mon_exp) begin
                n_pass++;
            end else begin
                $display("FAIL %s: got an=%b seg=%b dp=%b, expected an=%b seg=%b dp=%b",
                         mon_tag, an, seg, dp, mon_exp[11:8], mon_exp[7:1], mon_exp[0]);
            end
        end
    end

    // Expectation for the pins right after the next rising edge.
    task automatic push(input logic [3:0] e_an, input logic [6:0] e_seg, input logic e_dp,
                        input string tag);
        @(posedge clk);
        #1;
        exp_q.push_back({e_an, e_seg, e_dp});
        tag_q.push_back(tag);
    endtask

    task automatic set_digits(input logic [3:0] s1, input logic [3:0] s10,
                              input logic [3:0] m1, input logic [3:0] m10);
        sec_1s_in  = s1;
        sec_10s_in = s10;
        min_1s_in  = m1;
        min_10s_in = m10;
    endtask

    // One digit slot: three lit cycles followed by the blank cycle.
    task automatic slot(input int idx, input logic [6:0] glyph, input bit hide,
                        input string tag);
        logic [3:0] e_an;
        e_an = ~(4'b0001 << idx);
        for (int i = 0; i < 3; i++) begin
            push(e_an, hide ? BL : glyph, (idx != 2), $sformatf("%s_d%0d_lit%0d", tag, idx, i));
        end
        push(4'b1111, BL, 1'b1, $sformatf("%s_d%0d_blank", tag, idx));
    endtask

    task automatic scan(input logic [6:0] g0, input logic [6:0] g1, input logic [6:0] g2,
                        input logic [6:0] g3, input logic [3:0] hide, input string tag);
        slot(0, g0, hide[0], tag);
        slot(1, g1, hide[1], tag);
        slot(2, g2, hide[2], tag);
        slot(3, g3, hide[3], tag);
    endtask

    initial begin
        rst = 1'b1;
        adj = 1'b0;
        sel = 1'b0;
        set_digits(4'd5, 4'd4, 4'd3, 4'd2);

        repeat (2) @(posedge clk);
        push(4'b1111, BL, 1'b1, "reset");
        rst = 1'b0;

        // First scan shows the reset snapshot (all zeros).
        scan(G0, G0, G0, Z3, 4'b0000, "scan0");
        scan(G5, G4, G3, G2, 4'b0000, "scan1");

        // Inputs change mid-scan; the running scan must keep the old snapshot.
        slot(0, G5, 1'b0, "scan2");
        set_digits(4'hC, 4'd1, 4'd7, 4'd0);
        slot(1, G4, 1'b0, "scan2");
        slot(2, G3, 1'b0, "scan2");
        slot(3, G2, 1'b0, "scan2");

        set_digits(4'd5, 4'd4, 4'd3, 4'd2);
        scan(DASH, G1, G7, Z3, 4'b0000, "scan3");

        // Blink: 16 visible cycles (one scan), 16 hidden, and so on.
        adj = 1'b1;
        sel = 1'b1;
        scan(G5, G4, G3, G2, 4'b0000, "blink_vis0");
        slot(0, G5, 1'b1, "blink_hid0");
        slot(1, G4, 1'b1, "blink_hid0");
        sel = 1'b0;
        slot(2, G3, 1'b1, "blink_hid0_sel0");
        slot(3, G2, 1'b1, "blink_hid0_sel0");
        scan(G5, G4, G3, G2, 4'b0000, "blink_vis1");
        slot(0, G5, 1'b0, "blink_hid1");
        slot(1, G4, 1'b0, "blink_hid1");
        slot(2, G3, 1'b1, "blink_hid1");
        adj = 1'b0;
        slot(3, G2, 1'b0, "adj_off");

        // Reset during digit 2 aborts the slot and clears the snapshot.
        slot(0, G5, 1'b0, "scan8");
        slot(1, G4, 1'b0, "scan8");
        push(4'b1011, G3, 1'b0, "scan8_d2_lit0");
        rst = 1'b1;
        push(4'b1111, BL, 1'b1, "midscan_reset");
        rst = 1'b0;
        push(4'b1110, G0, 1'b1, "post_reset_d0_lit0");
        push(4'b1110, G0, 1'b1, "post_reset_d0_lit1");
        push(4'b1110, G0, 1'b1, "post_reset_d0_lit2");
        push(4'b1111, BL, 1'b1, "post_reset_d0_blank");

        @(negedge clk);
        @(negedge clk);
        n_checks++;
        if (exp_q.size() == 0) begin
            n_pass++;
        end else begin
            $display("FAIL scoreboard_drain: got %0d pending entries, expected 0", exp_q.size());
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
